// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and sizes for the 8-digit display scan controller.
// Imported by the interface, the index helper and the top-level FSM.
package seg_scan_pkg;

  localparam int NDIG  = 8;
  localparam int IDX_W = 3;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Extract the nibble for digit idx from a packed display word.
  function automatic logic [NIB_W-1:0] nib_of(input logic [NDIG*NIB_W-1:0] word,
                                              input logic [IDX_W-1:0]      idx);
    return word[idx*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: scan controls in, decoder select and nibble out.
// The master side drives run/digit_en/data; the controller is the slave.
interface seg_scan_if;
  import seg_scan_pkg::*;

  logic                  run;
  logic [NDIG-1:0]       digit_en;
  logic [NDIG*NIB_W-1:0] data;
  logic [IDX_W-1:0]      sel;
  logic                  sel_en;
  logic [NIB_W-1:0]      nibble;
  logic                  frame_start;

  modport master (
    output run, digit_en, data,
    input  sel, sel_en, nibble, frame_start
  );

  modport slave (
    input  run, digit_en, data,
    output sel, sel_en, nibble, frame_start
  );

endinterface

// File: rtl/seg_scan_ctrl_scan_next_idx.sv
// Circular search for the next enabled digit strictly after cur.
// wrap flags that the search passed 7->0 (or landed back on cur itself).
module scan_next_idx
  import seg_scan_pkg::*;
(
  input  logic [IDX_W-1:0] cur,
  input  logic [NDIG-1:0]  mask,
  output logic [IDX_W-1:0] nxt,
  output logic             wrap
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    nxt   = cur;
    found = 1'b0;
    cand  = cur;
    // k = NDIG wraps cand back to cur, covering the single-enabled-digit case.
    for (int k = 1; k <= NDIG; k++) begin
      cand = cur + IDX_W'(k);
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan FSM for an 8-digit multiplexed display: blanking gap, dwell, advance,
// and a once-per-frame data snapshot so a frame never shows mixed data.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_sel;
  logic                  r_sel_en;
  logic [NIB_W-1:0]      r_nibble;
  logic                  r_frame_start;
  logic [NDIG*NIB_W-1:0] r_snap;

  logic [IDX_W-1:0]      w_adv_idx;
  logic                  w_adv_wrap;
  logic [IDX_W-1:0]      w_first_idx;
  logic                  w_first_wrap;

  scan_next_idx u_adv (
    .cur  (r_sel),
    .mask (bus.digit_en),
    .nxt  (w_adv_idx),
    .wrap (w_adv_wrap)
  );

  // Searching after index 7 yields the lowest set bit.
  scan_next_idx u_first (
    .cur  (IDX_W'(NDIG - 1)),
    .mask (bus.digit_en),
    .nxt  (w_first_idx),
    .wrap (w_first_wrap)
  );

  wire w_blank_done = (r_cnt == CNT_W'(BLANK_CYC - 1));
  wire w_show_done  = (r_cnt == CNT_W'(CLK_DIV - 1)) || !bus.digit_en[r_sel];

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_sel         <= '0;
      r_sel_en      <= 1'b0;
      r_nibble      <= '0;
      r_frame_start <= 1'b0;
      r_snap        <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (!bus.run || bus.digit_en == '0) begin
        r_state  <= ST_IDLE;
        r_sel_en <= 1'b0;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sel         <= w_first_idx;
            r_snap        <= bus.data;
            r_frame_start <= w_first_wrap;  // entry always counts as a wrap
            r_cnt         <= '0;
            r_state       <= ST_BLANK;
          end
          ST_BLANK: begin
            if (w_blank_done) begin
              r_state  <= ST_SHOW;
              r_sel_en <= 1'b1;
              r_nibble <= nib_of(r_snap, r_sel);
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_SHOW: begin
            if (w_show_done) begin
              r_sel    <= w_adv_idx;
              r_sel_en <= 1'b0;
              r_state  <= ST_BLANK;
              r_cnt    <= '0;
              if (w_adv_wrap) begin
                r_snap        <= bus.data;
                r_frame_start <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sel         = r_sel;
  assign bus.sel_en      = r_sel_en;
  assign bus.nibble      = r_nibble;
  assign bus.frame_start = r_frame_start;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an 8-digit display; sits directly upstream of the 3-to-8 enable decoder.
- Produces the 3-bit digit index `sel` and decoder enable `sel_en`; the decoder turns these into the one-hot digit strobe.
- Also outputs the 4-bit nibble of the digit being shown, for the segment encoder.
- Skips masked digits, inserts blanking gaps against ghosting, and snapshots display data once per frame so a frame never tears.

Parameters:
- CLK_DIV, 50000, SHOW dwell per digit in clk cycles; must be >= 1.
- BLANK_CYC, 16, blanking gap before each SHOW, in clk cycles (sel_en=0); must be >= 1.
- CNT_W, 16, counter width; must hold max(CLK_DIV, BLANK_CYC) - 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- run, input, 1: scan enable.
- digit_en, input, 8: per-digit mask; bit i=1 means digit i is scanned.
- data, input, 32: nibble i = data[4i+3:4i], displayed on digit i.
- sel, output, 3: digit index, drives the decoder `x` input.
- sel_en, output, 1: drives the decoder `en` input; high only in SHOW.
- nibble, output, 4: snapshot nibble of digit `sel`.
- frame_start, output, 1: one-cycle pulse when a data snapshot is taken.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous), clears:
  - state to IDLE and all counters to 0;
  - sel=0, sel_en=0, nibble=0, frame_start=0, snapshot register=0.
- Reset release: normal operation resumes on the first clk edge after rst_n deasserts.
- Reset asserted mid-operation aborts immediately; sel_en drops asynchronously.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - sel_en=0.
  - When run=1 and digit_en!=0 at an edge: sel <= lowest set bit of digit_en, snapshot <= data, frame_start=1, go to BLANK.
- BLANK:
  - sel_en=0; the counter runs 0..BLANK_CYC-1.
  - On the edge where the count is BLANK_CYC-1: go to SHOW, sel_en <= 1, nibble <= snapshot nibble[sel].
- SHOW:
  - sel_en=1; the counter runs 0..CLK_DIV-1.
  - On the edge where the count is CLK_DIV-1: sel <= next enabled index strictly after sel, circular 7->0; sel_en <= 0; go to BLANK.
  - If that step wraps (new index <= old index), also snapshot <= data and frame_start=1 for that cycle.
  - A single enabled digit always wraps, so it re-snapshots every dwell.
- Timing: with run rising at edge E0, sel_en is high from E0+BLANK_CYC for exactly CLK_DIV cycles. Digit period = CLK_DIV+BLANK_CYC cycles.
- run=0 or digit_en==0 in any state: next edge goes to IDLE, sel_en <= 0, sel holds its value.
- digit_en bit of the current sel cleared during SHOW: end the dwell early on the next edge, handled as a normal dwell end (advance + BLANK).
- digit_en bits set or cleared for other digits take effect at the next advance.
- Changes to `data` never alter `nibble` within a frame; only snapshot points update it.
- At most one digit is ever enabled: sel changes only while sel_en=0.

Decomposition:
- Package seg_scan_pkg:
  - state encoding constants ST_IDLE / ST_BLANK / ST_SHOW;
  - NDIG=8, IDX_W=3, NIB_W=4.
- Sub-module scan_next_idx (combinational):
  - inputs: cur[2:0], mask[7:0];
  - outputs: nxt[2:0] (first set bit after cur, circular) and wrap;
  - with cur=7 and mask=0 it is unused; the FSM guarantees mask!=0.
- The lowest-set-bit lookup for the IDLE entry reuses scan_next_idx with cur=7.

Test Plan (CLK_DIV=4, BLANK_CYC=2):
- Reset, then run=1, digit_en=8'hFF, data=32'h76543210 -> sel steps 0,1,...,7,0; each sel_en pulse is 4 cycles, separated by 2 low cycles; nibble equals sel; frame_start pulses at entry and at every 7->0 wrap (period 48 cycles).
- digit_en=8'b1010_0100 -> sel sequence 2,5,7,2; frame_start on each 7->2 step; sel_en never high with sel outside {2,5,7}.
- data changed from 32'h76543210 to 32'hFFFFFFFF while sel=3 is showing -> nibble stays 3,4,...,7 until the wrap, then reads F for all digits.
- Single digit digit_en=8'h10 -> sel stays 4; sel_en pattern 4 high / 2 low; frame_start every 6 cycles.
- run dropped mid-SHOW -> sel_en=0 on the next edge, state IDLE. Then digit_en=0 with run=1 -> stays IDLE.
- rst_n pulsed low mid-SHOW -> sel_en=0 immediately (asynchronous); after release with run=1, scanning restarts from the lowest enabled digit with a fresh snapshot.
